// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample constants and receiver FSM encoding.
package uart_pkg;
  localparam int         OVERSAMPLE = 16;
  localparam int         TICK_W     = $clog2(OVERSAMPLE);
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver driven by a 16x-baud tick: start-bit validation, mid-bit sampling,
// LSB-first deserialisation, optional parity, one-clock result strobe.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  logic                 rxs;
  rx_state_e            state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                 perr, perr_n, valid_n, ferr_n, pe_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      perr       <= perr_n;
      rx_data    <= data_n;
      rx_valid   <= valid_n;
      frame_err  <= ferr_n;
      parity_err <= pe_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    perr_n  = perr;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = frame_err;
    pe_n    = parity_err;
    if (tick_16) begin
      unique case (state)
        IDLE: if (!rxs) begin
          state_n = START;
          tick_n  = '0;
          perr_n  = 1'b0;
        end
        START: begin
          if (tick_cnt == MID_TICK) begin
            // A glitch shorter than half a bit is rejected here.
            state_n = rxs ? IDLE : DATA;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            shreg_n = {rxs, shreg[DATA_BITS-1:1]};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            perr_n  = ((^shreg) ^ rxs) != PAR_ODD;
            state_n = STOP;
          end
        end
        STOP: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            valid_n = 1'b1;
            data_n  = shreg;
            ferr_n  = ~rxs;
            pe_n    = perr;
            // A low stop bit means break/framing: wait for the line to recover.
            state_n = rxs ? IDLE : WAIT_HI;
          end
        end
        WAIT_HI: if (rxs) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: an 8N1 instance and an even-parity instance.
module tb_uart_rx_16x;
  logic       clk = 1'b0;
  logic       rst, tick_16, rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, perr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .rst(rst), .tick_16(tick_16), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .frame_err(ferr_a),
    .parity_err(perr_a), .busy(busy_a)
  );

  uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .rst(rst), .tick_16(tick_16), .rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .frame_err(ferr_b),
    .parity_err(perr_b), .busy(busy_b)
  );

  typedef struct { logic [7:0] data; logic ferr; logic perr; } exp_t;
  typedef enum { K_BUSY_A, K_BUSY_B, K_DATA_A, K_VALID_A, K_FERR_A, K_PERR_A,
                 K_NSTROBE_A, K_LAT_A, K_GAP_A, K_PEND_A, K_PEND_B } kind_e;
  typedef struct { kind_e kind; int idx; longint ref_t; longint exp; string name; } req_t;

  exp_t   exp_a[$], exp_b[$];
  req_t   req_q[$];
  longint t_a[$];
  longint t_start_a;
  int     n_cmp = 0, n_bad = 0;

  // tick_16 high for one clock out of every four
  initial begin
    tick_16 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_16 = 1'b1;
      @(negedge clk);
      tick_16 = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still going at 1ms, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pops expectations on every strobe, then services level checks.
  initial begin
    exp_t   e;
    req_t   r;
    longint act;
    logic   prev_a = 1'b0, prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        t_a.push_back(longint'($time));
        n_cmp++;
        if (prev_a) begin
          n_bad++;
          $display("FAIL strobe_a_width: valid high 2 clks, required 1");
        end else if (exp_a.size() == 0) begin
          n_bad++;
          $display("FAIL strobe_a_unexpected: data=%h ferr=%b perr=%b, required no strobe",
                   data_a, ferr_a, perr_a);
        end else begin
          e = exp_a.pop_front();
          if ({data_a, ferr_a, perr_a} !== {e.data, e.ferr, e.perr}) begin
            n_bad++;
            $display("FAIL strobe_a: data=%h ferr=%b perr=%b, required data=%h ferr=%b perr=%b",
                     data_a, ferr_a, perr_a, e.data, e.ferr, e.perr);
          end
        end
      end
      if (valid_b) begin
        n_cmp++;
        if (prev_b) begin
          n_bad++;
          $display("FAIL strobe_b_width: valid high 2 clks, required 1");
        end else if (exp_b.size() == 0) begin
          n_bad++;
          $display("FAIL strobe_b_unexpected: data=%h ferr=%b perr=%b, required no strobe",
                   data_b, ferr_b, perr_b);
        end else begin
          e = exp_b.pop_front();
          if ({data_b, ferr_b, perr_b} !== {e.data, e.ferr, e.perr}) begin
            n_bad++;
            $display("FAIL strobe_b: data=%h ferr=%b perr=%b, required data=%h ferr=%b perr=%b",
                     data_b, ferr_b, perr_b, e.data, e.ferr, e.perr);
          end
        end
      end
      prev_a = valid_a;
      prev_b = valid_b;
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        case (r.kind)
          K_BUSY_A:    act = longint'(busy_a);
          K_BUSY_B:    act = longint'(busy_b);
          K_DATA_A:    act = longint'(data_a);
          K_VALID_A:   act = longint'(valid_a);
          K_FERR_A:    act = longint'(ferr_a);
          K_PERR_A:    act = longint'(perr_a);
          K_NSTROBE_A: act = longint'(t_a.size());
          K_LAT_A:     act = (r.idx < t_a.size()) ? t_a[r.idx] - r.ref_t : -1;
          K_GAP_A:     act = (r.idx >= 1 && r.idx < t_a.size()) ? t_a[r.idx] - t_a[r.idx-1] : -1;
          K_PEND_A:    act = longint'(exp_a.size());
          default:     act = longint'(exp_b.size());
        endcase
        n_cmp++;
        if (act != r.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d, required %0d", r.name, act, r.exp);
        end
      end
    end
  end

  task automatic chk(input kind_e k, input int idx, input longint rt, input longint e,
                     input string nm);
    req_t r;
    r.kind = k; r.idx = idx; r.ref_t = rt; r.exp = e; r.name = nm;
    req_q.push_back(r);
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick_16) k++;
    end
  endtask

  task automatic bit_a(input logic b);
    rx_a = b; wait_ticks(16); #1;
  endtask

  task automatic bit_b(input logic b);
    rx_b = b; wait_ticks(16); #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop_b);
    t_start_a = longint'($time);
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
    bit_a(stop_b);
  endtask

  task automatic send_b(input logic [7:0] d, input logic par);
    bit_b(1'b0);
    for (int i = 0; i < 8; i++) bit_b(d[i]);
    bit_b(par);
    bit_b(1'b1);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic f, input logic p);
    exp_t e;
    e.data = d; e.ferr = f; e.perr = p;
    return e;
  endfunction

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(K_DATA_A, 0, 0, 0, "reset_rx_data");
    chk(K_VALID_A, 0, 0, 0, "reset_rx_valid");
    chk(K_FERR_A, 0, 0, 0, "reset_frame_err");
    chk(K_PERR_A, 0, 0, 0, "reset_parity_err");
    chk(K_BUSY_A, 0, 0, 0, "reset_busy_a");
    chk(K_BUSY_B, 0, 0, 0, "reset_busy_b");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(4); #1;

    // 1: 0x55 8N1, strobe 153 ticks + 1 clk after the start edge
    exp_a.push_back(mk(8'h55, 1'b0, 1'b0));
    send_a(8'h55, 1'b1);
    chk(K_BUSY_A, 0, 0, 0, "t1_busy_after");
    chk(K_LAT_A, 0, t_start_a, 6124, "t1_latency_ns");
    chk(K_NSTROBE_A, 0, 0, 1, "t1_strobes");

    // 2: even parity, good then bad parity bit
    exp_b.push_back(mk(8'hA3, 1'b0, 1'b0));
    send_b(8'hA3, 1'b0);
    exp_b.push_back(mk(8'hA3, 1'b0, 1'b1));
    send_b(8'hA3, 1'b1);
    chk(K_BUSY_B, 0, 0, 0, "t2_busy_after");

    // 3: false start, low for only 5 ticks
    rx_a = 1'b0; wait_ticks(5); #1;
    rx_a = 1'b1;
    chk(K_BUSY_A, 0, 0, 1, "t3_busy_in_start");
    wait_ticks(20); #1;
    chk(K_BUSY_A, 0, 0, 0, "t3_busy_after");
    chk(K_NSTROBE_A, 0, 0, 1, "t3_no_strobe");

    // 4: stop bit low, line held low 40 ticks total
    exp_a.push_back(mk(8'h3C, 1'b1, 1'b0));
    send_a(8'h3C, 1'b0);
    wait_ticks(24); #1;
    chk(K_BUSY_A, 0, 0, 1, "t4_busy_wait_hi");
    chk(K_NSTROBE_A, 0, 0, 2, "t4_single_strobe");
    rx_a = 1'b1;
    wait_ticks(4); #1;
    chk(K_BUSY_A, 0, 0, 0, "t4_busy_after_high");

    // 5: reset during bit 4 of 0xF0, then a clean 0x0F
    bit_a(1'b0);
    for (int i = 0; i < 4; i++) bit_a(1'b0);
    rx_a = 1'b1; wait_ticks(8); #1;
    rst = 1'b1;
    chk(K_BUSY_A, 0, 0, 0, "t5_busy_in_reset");
    chk(K_DATA_A, 0, 0, 0, "t5_data_in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(20); #1;
    exp_a.push_back(mk(8'h0F, 1'b0, 1'b0));
    send_a(8'h0F, 1'b1);
    chk(K_NSTROBE_A, 0, 0, 3, "t5_strobes");

    // 6: three frames back to back
    exp_a.push_back(mk(8'h01, 1'b0, 1'b0));
    exp_a.push_back(mk(8'hFF, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h80, 1'b0, 1'b0));
    send_a(8'h01, 1'b1);
    send_a(8'hFF, 1'b1);
    send_a(8'h80, 1'b1);
    wait_ticks(4); #1;
    chk(K_GAP_A, 4, 0, 6400, "t6_gap_1_ns");
    chk(K_GAP_A, 5, 0, 6400, "t6_gap_2_ns");

    wait_ticks(20); #1;
    chk(K_PEND_A, 0, 0, 0, "pending_a");
    chk(K_PEND_B, 0, 0, 0, "pending_b");
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
